// File: rtl/jk_seq_ctrl.sv
// Sequencing controller for a bank of falling-edge JK flip-flops (74HC112 style).
// Runs hold/up/down/load commands for a latched number of steps with a BUSY/DONE handshake.
module jk_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             START,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] STEPS,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             CO,
  output logic [1:0]       fsm_state
);

  // Handshake: START is a level request sampled on a falling edge only in IDLE.
  // BUSY is high for exactly STEPS cycles, then DONE is high for one cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  localparam logic [1:0]       M_HOLD = 2'b00;
  localparam logic [1:0]       M_UP   = 2'b01;
  localparam logic [1:0]       M_DOWN = 2'b10;
  localparam logic [1:0]       M_LOAD = 2'b11;
  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MOD - 1);

  state_t           state, state_next;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] remaining;
  logic             first_step;
  logic [WIDTH-1:0] q_r;
  logic             co_r;
  logic [WIDTH-1:0] nxt;
  logic             wrap;

  always_ff @(negedge CLK or negedge R) begin
    if (!R) state <= IDLE;
    else    state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (START) state_next = (STEPS == '0) ? FINISH : RUN;
      RUN:     if (remaining == WIDTH'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    J    = '0;
    K    = '0;
    case (state)
      RUN: begin
        BUSY = 1'b1;
        J    = q_r ^ nxt;
        K    = q_r ^ nxt;
      end
      FINISH:  DONE = 1'b1;
      default: ;
    endcase
  end

  // Out-of-range states fall back to 0 (up) or MOD-1 (down).
  always_comb begin
    nxt = q_r;
    case (mode_r)
      M_UP:   nxt = ({1'b0, q_r} >= MOD_X - 1'b1) ? '0 : q_r + WIDTH'(1);
      M_DOWN: nxt = (q_r == '0 || {1'b0, q_r} >= MOD_X) ? TOP : q_r - WIDTH'(1);
      M_LOAD: if (first_step) nxt = ({1'b0, d_r} < MOD_X) ? d_r : '0;
      M_HOLD: nxt = q_r;
      default: nxt = q_r;
    endcase
  end

  assign wrap = (state == RUN) &&
                ((mode_r == M_UP && q_r == TOP) || (mode_r == M_DOWN && q_r == '0));

  always_ff @(negedge CLK or negedge R) begin
    if (!R) begin
      mode_r     <= M_HOLD;
      d_r        <= '0;
      remaining  <= '0;
      first_step <= 1'b0;
      q_r        <= '0;
      co_r       <= 1'b0;
    end else begin
      // J/K are zero outside RUN, so the bank holds there without a separate enable.
      q_r  <= (J & ~q_r) | (~K & q_r);
      co_r <= wrap;
      case (state)
        IDLE: if (START) begin
          mode_r     <= MODE;
          d_r        <= D;
          remaining  <= STEPS;
          first_step <= 1'b1;
        end
        RUN: begin
          remaining  <= remaining - WIDTH'(1);
          first_step <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Q         = q_r;
  assign CO        = co_r;
  assign fsm_state = state;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl: table of commands with per-step scoreboard of Q/CO/J/K,
// plus hand-written reset, zero-step, busy-start and mid-run reset sequences.
module tb_jk_seq_ctrl;
  localparam int W   = 4;
  localparam int MOD = 10;

  logic         CLK = 1'b0;
  logic         R   = 1'b0;
  logic         START = 1'b0;
  logic [1:0]   MODE  = 2'b00;
  logic [W-1:0] D     = '0;
  logic [W-1:0] STEPS = '0;
  logic [W-1:0] J, K, Q;
  logic         BUSY, DONE, CO;
  logic [1:0]   fsm_state;

  jk_seq_ctrl #(.WIDTH(W), .MOD(MOD)) dut (
    .CLK(CLK), .R(R), .START(START), .MODE(MODE), .D(D), .STEPS(STEPS),
    .J(J), .K(K), .Q(Q), .BUSY(BUSY), .DONE(DONE), .CO(CO), .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic [W-1:0] steps;
    bit           poke;
    logic [W-1:0] exp_q;
    int           exp_co;
  } vec_t;

  vec_t         vecs[13];
  logic [W:0]   exp_q[$];
  logic [W-1:0] jk_q[$];
  logic [W-1:0] m_q = '0;
  logic         prev_busy = 1'b0;
  logic [W:0]   e_step;
  logic [W-1:0] e_jk;
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic check(input string nm, input int got, input int expv);
    n_cmp++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [1:0] m, input logic [W-1:0] q,
                                                input logic [W-1:0] d, input bit first);
    int qi;
    qi = int'(q);
    case (m)
      2'b01:   return (qi >= MOD - 1) ? '0 : W'(qi + 1);
      2'b10:   return (qi == 0 || qi >= MOD) ? W'(MOD - 1) : W'(qi - 1);
      2'b11:   return first ? ((int'(d) < MOD) ? d : '0) : q;
      default: return q;
    endcase
  endfunction

  // Push expected per-step J/K and {CO,Q} for a command, advancing the model.
  task automatic push_cmd(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] s);
    logic [W-1:0] n;
    logic         co;
    for (int k = 1; k <= int'(s); k++) begin
      n  = model_next(m, m_q, d, k == 1);
      co = (m == 2'b01 && int'(m_q) == MOD - 1) || (m == 2'b10 && m_q == '0);
      jk_q.push_back(m_q ^ n);
      exp_q.push_back({co, n});
      m_q = n;
    end
  endtask

  // Scoreboard monitor, sampling on the rising edge (outputs change on the falling edge).
  always @(posedge CLK) begin
    if (!R) begin
      prev_busy <= 1'b0;
    end else begin
      if (prev_busy) begin
        if (exp_q.size() == 0) check("step_underflow", 1, 0);
        else begin
          e_step = exp_q.pop_front();
          check("step_q", int'(Q), int'(e_step[W-1:0]));
          check("step_co", int'(CO), int'(e_step[W]));
        end
      end
      if (BUSY) begin
        if (jk_q.size() == 0) check("jk_underflow", 1, 0);
        else begin
          e_jk = jk_q.pop_front();
          check("j", int'(J), int'(e_jk));
          check("k", int'(K), int'(e_jk));
        end
      end
      prev_busy <= BUSY;
    end
  end

  // Called at posedge+1; returns at posedge+1 one cycle after DONE.
  task automatic run_cmd(input vec_t v);
    int  busy_n, co_n;
    bit  done;
    logic [W-1:0] q_fin;
    START = 1'b1; MODE = v.mode; D = v.d; STEPS = v.steps;
    push_cmd(v.mode, v.d, v.steps);
    @(posedge CLK); #1;
    START = 1'b0;
    MODE  = 2'($urandom_range(0, 3));
    D     = W'($urandom_range(0, 15));
    STEPS = W'($urandom_range(0, 15));
    busy_n = 0; co_n = 0; done = 0; q_fin = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (BUSY) busy_n++;
      if (CO) co_n++;
      if (BUSY && DONE) check("busy_and_done", 1, 0);
      if (DONE) begin
        done  = 1;
        q_fin = Q;
        START = 1'b0;
      end else begin
        START = v.poke && BUSY;
        @(posedge CLK); #1;
      end
    end
    START = 1'b0;
    check("done_seen", int'(done), 1);
    check("final_q", int'(q_fin), int'(v.exp_q));
    check("busy_cycles", busy_n, int'(v.steps));
    check("co_cycles", co_n, v.exp_co);
    @(posedge CLK); #1;
    check("done_width", int'({DONE, BUSY}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b11, 4'd7,  4'd1, 1'b0, 4'd7, 0};
    vecs[1]  = '{2'b01, 4'd0,  4'd5, 1'b0, 4'd2, 1};
    vecs[2]  = '{2'b11, 4'd0,  4'd1, 1'b0, 4'd0, 0};
    vecs[3]  = '{2'b10, 4'd0,  4'd2, 1'b0, 4'd8, 1};
    vecs[4]  = '{2'b11, 4'd6,  4'd3, 1'b0, 4'd6, 0};
    vecs[5]  = '{2'b01, 4'd0,  4'd0, 1'b0, 4'd6, 0};
    vecs[6]  = '{2'b11, 4'd12, 4'd1, 1'b0, 4'd0, 0};
    vecs[7]  = '{2'b01, 4'd0,  4'd4, 1'b1, 4'd4, 0};
    vecs[8]  = '{2'b10, 4'd0,  4'd5, 1'b0, 4'd9, 1};
    vecs[9]  = '{2'b00, 4'd3,  4'd3, 1'b0, 4'd9, 0};
    vecs[10] = '{2'b01, 4'd0,  4'd1, 1'b0, 4'd0, 1};
    vecs[11] = '{2'b01, 4'd0,  4'd2, 1'b0, 4'd2, 0};
    vecs[12] = '{2'b11, 4'd15, 4'd2, 1'b0, 4'd0, 0};

    // Reset held with clock running and START asserted.
    START = 1'b1; MODE = 2'b01; STEPS = 4'd3;
    repeat (4) begin
      @(posedge CLK); #1;
      check("reset_outputs", int'({Q, J, K, BUSY, DONE, CO, fsm_state}), 0);
    end
    START = 1'b0;
    R = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("idle_after_reset", int'({Q, BUSY, DONE, fsm_state}), 0);
    end

    for (int i = 0; i < 13; i++) run_cmd(vecs[i]);

    // Up count of 8 aborted by reset between the 3rd and 4th step.
    START = 1'b1; MODE = 2'b01; D = '0; STEPS = 4'd8;
    push_cmd(2'b01, '0, 4'd8);
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("pre_abort_q", int'(Q), 3);
    R = 1'b0;
    #1;
    check("abort_async", int'({Q, BUSY, DONE, CO}), 0);
    exp_q.delete();
    jk_q.delete();
    m_q = '0;
    repeat (2) begin
      @(posedge CLK); #1;
      check("abort_no_done", int'({Q, BUSY, DONE}), 0);
    end
    R = 1'b1;
    @(posedge CLK); #1;
    run_cmd('{2'b01, 4'd0, 4'd3, 1'b0, 4'd3, 0});

    check("scoreboard_empty", exp_q.size() + jk_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
